master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/bus_pkg.sv | 22 ++
 rtl/tx_shift.sv | 32 +++
 rtl/master_port.sv | 137 +++++++++++++
 tb/tb_master_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM state encoding and field widths for the serial bus master port
package bus_pkg;

  localparam int HDR_W  = 16;
  localparam int DATA_W = 8;

  localparam logic [2:0] SID_NONE = 3'd7;
  localparam logic [3:0] MID_NONE = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_REQ     = 4'd1,
    ST_GRANTED = 4'd2,
    ST_HDR     = 4'd3,
    ST_WDATA   = 4'd4,
    ST_RESP    = 4'd5,
    ST_SPLIT   = 4'd6,
    ST_RDATA   = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

endpackage

// File: rtl/tx_shift.sv
// rtl/tx_shift.sv - parallel-load MSB-first serializer with 4-bit bit counter for header and write data
module tx_shift
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [HDR_W-1:0] load_data,
  input  logic             shift,
  output logic             bit_out,
  output logic [3:0]       bit_cnt
);

  logic [HDR_W-1:0] sreg;

  // A load always restarts the count, so one phase never inherits the other's bit position
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= {sreg[HDR_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign bit_out = sreg[HDR_W-1];

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - serial bus master port: arbitration, header/write serializing, split-aware response capture
// Optional RESP timeout compiled in when MASTER_PORT_TIMEOUT_EN is defined.
module master_port
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [2:0]        sid,
  input  logic [11:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              m_req,
  input  logic              m_grant,
  input  logic              bus_util_in,
  output logic              bus_util_out,
  output logic              tx_data,
  output logic              tx_valid,
  input  logic              rx_data,
  input  logic              rx_valid,
  input  logic              split
);

  state_t              state, state_nxt;
  logic                rw_q;
  logic [2:0]          sid_q;
  logic [11:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          rx_cnt;
  logic                sh_load, sh_bit;
  logic [3:0]          sh_cnt;
  logic [HDR_W-1:0]    sh_data;
  logic                rx_take;
  logic                tmo;
  logic                unused_ok;

  assign unused_ok = ^{bus_util_in, MID_NONE, 8'(TIMEOUT)};

`ifdef MASTER_PORT_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ST_RESP) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo = (state == ST_RESP) && !split && !rx_valid && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // Split only matters in RESP; SPLIT and RDATA take the next valid bit unconditionally
  assign rx_take = rx_valid && (((state == ST_RESP) && !split) ||
                                (state == ST_SPLIT) || (state == ST_RDATA));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_REQ;
      ST_REQ:     if (m_grant) state_nxt = ST_GRANTED;
      ST_GRANTED: state_nxt = ST_HDR;
      ST_HDR:     if (sh_cnt == 4'd15) state_nxt = rw_q ? ST_WDATA : ST_RESP;
      ST_WDATA:   if (sh_cnt == 4'd7) state_nxt = ST_RESP;
      ST_RESP: begin
        if (split)         state_nxt = ST_SPLIT;
        else if (rx_valid) state_nxt = rw_q ? ST_DONE : ST_RDATA;
        else if (tmo)      state_nxt = ST_DONE;
      end
      ST_SPLIT:   if (rx_valid) state_nxt = rw_q ? ST_DONE : ST_RDATA;
      ST_RDATA:   if (rx_valid && rx_cnt == 4'd7) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign sh_load = (state == ST_GRANTED) || ((state == ST_HDR) && (sh_cnt == 4'd15) && rw_q);
  assign sh_data = (state == ST_GRANTED) ? {sid_q, addr_q, rw_q} : {wdata_q, 8'h00};

  tx_shift u_tx_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_data),
    .shift     (tx_valid),
    .bit_out   (sh_bit),
    .bit_cnt   (sh_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rw_q    <= 1'b0;
      sid_q   <= SID_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      rx_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        rw_q    <= rw;
        sid_q   <= sid;
        addr_q  <= addr;
        wdata_q <= wdata;
        err     <= 1'b0;
        rx_cnt  <= '0;
      end
      if (rx_take) begin
        if (rw_q) begin
          err <= ~rx_data;
        end else begin
          rdata  <= {rdata[DATA_W-2:0], rx_data};
          rx_cnt <= rx_cnt + 4'd1;
        end
      end
      if (tmo) begin
        err   <= 1'b1;
        rdata <= '0;
      end
    end
  end

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign m_req        = (state == ST_REQ);
  assign bus_util_out = !(state inside {ST_GRANTED, ST_HDR, ST_WDATA, ST_RESP});
  assign tx_valid     = (state inside {ST_HDR, ST_WDATA});
  assign tx_data      = tx_valid & sh_bit;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - randomized transaction bench for master_port with a timeline reference model
module tb_master_port;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [2:0] sid;
  logic [11:0] addr;
  logic [7:0] wdata;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic       m_req, m_grant, bus_util_in, bus_util_out;
  logic       tx_data, tx_valid, rx_data, rx_valid, split;

  master_port #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .sid(sid), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .m_req(m_req), .m_grant(m_grant), .bus_util_in(bus_util_in), .bus_util_out(bus_util_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data), .rx_valid(rx_valid), .split(split)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  logic chk_en = 1'b0;
  logic e_busy, e_done, e_mreq, e_bus, e_txv, e_txd, e_err;
  logic [7:0] e_rdata;
  logic       m_err;
  logic [7:0] m_rdata;
  logic [15:0] cap_hdr;
  logic [7:0]  cap_wd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",         16'(busy),         16'(e_busy));
      check("done",         16'(done),         16'(e_done));
      check("m_req",        16'(m_req),        16'(e_mreq));
      check("bus_util_out", 16'(bus_util_out), 16'(e_bus));
      check("tx_valid",     16'(tx_valid),     16'(e_txv));
      check("tx_data",      16'(tx_data),      16'(e_txd));
      check("err",          16'(err),          16'(e_err));
      check("rdata",        16'(rdata),        16'(e_rdata));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic b, input logic d, input logic q, input logic u,
                            input logic v, input logic t);
    e_busy = b; e_done = d; e_mreq = q; e_bus = u; e_txv = v; e_txd = t;
    e_err = m_err; e_rdata = m_rdata;
  endtask

  task automatic exp_idle();  expect_out(0, 0, 0, 1, 0, 0); endtask
  task automatic exp_req();   expect_out(1, 0, 1, 1, 0, 0); endtask
  task automatic exp_held();  expect_out(1, 0, 0, 0, 0, 0); endtask
  task automatic exp_free();  expect_out(1, 0, 0, 1, 0, 0); endtask
  task automatic exp_done();  expect_out(1, 1, 0, 1, 0, 0); endtask
  task automatic exp_tx(input logic t); expect_out(1, 0, 0, 0, 1, t); endtask

  task automatic abort_by_reset();
    rst = 1'b1; start = 1'b0; split = 1'b0; rx_valid = 1'b0;
    cyc(); rst = 1'b0; m_err = 1'b0; m_rdata = 8'h00; exp_idle();
    cyc(); exp_idle();
  endtask

  // mode: 0 direct response, 1 split then response, 2 silent slave
  task automatic txn(input logic t_rw, input logic [2:0] t_sid, input logic [11:0] t_addr,
                     input logic [7:0] t_wd, input int gnt_dly, input int mode, input int wait1,
                     input int wait2, input logic [7:0] rbyte, input logic wresp, input int rst_bit);
    logic [15:0] hdr;
    hdr = {t_sid, t_addr, t_rw};
    start = 1'b1; rw = t_rw; sid = t_sid; addr = t_addr; wdata = t_wd;
    cyc(); m_err = 1'b0; exp_req();
    rw = 1'($urandom); sid = 3'($urandom); addr = 12'($urandom); wdata = 8'($urandom);
    for (int i = 0; i < gnt_dly; i++) begin
      start = 1'($urandom); bus_util_in = 1'($urandom);
      cyc(); exp_req();
    end
    start = 1'b0; m_grant = 1'b1; bus_util_in = 1'($urandom);
    cyc(); m_grant = 1'b0; exp_held();
    for (int i = 0; i < 16; i++) begin
      start = 1'($urandom); split = 1'($urandom); rx_valid = 1'($urandom);
      cyc(); exp_tx(hdr[15-i]); cap_hdr = {cap_hdr[14:0], tx_data};
      if (i == rst_bit) begin
        abort_by_reset();
        return;
      end
    end
    if (t_rw) begin
      for (int i = 0; i < 8; i++) begin
        start = 1'($urandom); split = 1'($urandom); rx_valid = 1'($urandom);
        cyc(); exp_tx(t_wd[7-i]); cap_wd = {cap_wd[6:0], tx_data};
      end
    end
    start = 1'b0; split = 1'b0; rx_valid = 1'b0;
    cyc(); exp_held();
    if (mode == 2) begin
`ifdef MASTER_PORT_TIMEOUT_EN
      for (int i = 1; i < TMO; i++) begin cyc(); exp_held(); end
      cyc(); m_err = 1'b1; m_rdata = 8'h00; exp_done();
      cyc(); exp_idle();
`else
      for (int i = 0; i < 12; i++) begin cyc(); exp_held(); end
      abort_by_reset();
`endif
      return;
    end
    for (int i = 0; i < wait1; i++) begin cyc(); exp_held(); end
    if (mode == 1) begin
      split = 1'b1; rx_valid = 1'($urandom); rx_data = 1'($urandom);
      cyc(); split = 1'b0; rx_valid = 1'b0; exp_free();
      for (int i = 0; i < wait2; i++) begin cyc(); exp_free(); end
    end
    rx_valid = 1'b1; rx_data = t_rw ? wresp : rbyte[7];
    cyc(); rx_valid = 1'b0;
    if (t_rw) begin
      m_err = ~wresp; exp_done();
    end else begin
      m_rdata = {m_rdata[6:0], rbyte[7]}; exp_free();
      for (int b = 6; b >= 0; b--) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          split = 1'($urandom); rx_data = 1'($urandom);
          cyc(); exp_free();
        end
        split = 1'b0; rx_valid = 1'b1; rx_data = rbyte[b];
        cyc(); rx_valid = 1'b0;
        m_rdata = {m_rdata[6:0], rbyte[b]};
        if (b == 0) exp_done(); else exp_free();
      end
    end
    start = 1'($urandom); rw = 1'($urandom);
    cyc(); start = 1'b0; exp_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; sid = '0; addr = '0; wdata = '0;
    m_grant = 1'b0; bus_util_in = 1'b1; rx_data = 1'b0; rx_valid = 1'b0; split = 1'b0;
    m_err = 1'b0; m_rdata = 8'h00; cap_hdr = '0; cap_wd = '0;
    cyc(); exp_idle(); chk_en = 1'b1;
    cyc(); rst = 1'b0; exp_idle();
    cyc(); exp_idle();

    txn(1'b1, 3'd2, 12'hABC, 8'h5A, 3, 0, 0, 0, 8'h00, 1'b1, -1);
    check("hdr_bits_5579", cap_hdr, 16'h5579);
    check("wdata_bits_5a", 16'(cap_wd), 16'h005A);
    check("write_err_clear", 16'(err), 16'h0000);

    txn(1'b0, 3'd5, 12'h123, 8'h00, 1, 0, 1, 0, 8'hC3, 1'b0, -1);
    check("rdata_c3", 16'(rdata), 16'h00C3);

    txn(1'b0, 3'd1, 12'h3F0, 8'h00, 0, 1, 2, 3, 8'h96, 1'b0, -1);
    check("rdata_96_split", 16'(rdata), 16'h0096);

    txn(1'b1, 3'd3, 12'h001, 8'h33, 2, 0, 3, 0, 8'h00, 1'b0, -1);
    check("write_err_nak", 16'(err), 16'h0001);

    txn(1'b0, 3'd4, 12'h777, 8'h00, 2, 2, 0, 0, 8'h00, 1'b0, -1);
`ifdef MASTER_PORT_TIMEOUT_EN
    check("timeout_err", 16'(err), 16'h0001);
    check("timeout_rdata", 16'(rdata), 16'h0000);
`else
    check("no_timeout_abort_err", 16'(err), 16'h0000);
`endif

    txn(1'b1, 3'd6, 12'h0F0, 8'hFF, 0, 0, 0, 0, 8'h00, 1'b0, 7);
    check("busy_after_rst", 16'(busy), 16'h0000);
    txn(1'b0, 3'd6, 12'h0F0, 8'h00, 1, 0, 0, 0, 8'hA5, 1'b0, -1);
    check("rdata_a5_after_rst", 16'(rdata), 16'h00A5);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), 3'($urandom), 12'($urandom), 8'($urandom), $urandom_range(0, 4),
          $urandom_range(0, 1), $urandom_range(0, TMO - 1), $urandom_range(0, 8),
          8'($urandom), 1'($urandom), -1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
